// File: rtl/ppa_pkg.sv
// Shared types and elaboration helpers for the parallel-prefix adder/subtractor family.
package ppa_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic bit is_pow2(input int w);
    return (w > 0) && ((w & (w - 1)) == 0);
  endfunction

  // Brent-Kung depth: clog2(w) up-sweep levels plus clog2(w)-1 down-sweep levels.
  function automatic int bk_levels(input int w);
    return 2 * $clog2(w) - 1;
  endfunction

endpackage

// File: rtl/ppa_sub_pipe_if.sv
// Operand/result stream interface of the pipelined prefix subtractor.
interface ppa_sub_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/ppa_cells.sv
// Prefix operator cells shared by the ppa_* adders and subtractors.
module ppa_black
  import ppa_pkg::*;
(
  input  pg_t hi,
  input  pg_t lo,
  output pg_t o
);
  assign o = '{p: hi.p & lo.p, g: hi.g | (hi.p & lo.g)};
endmodule

module ppa_grey
  import ppa_pkg::*;
(
  input  pg_t  hi,
  input  logic lo_g,
  output logic g
);
  assign g = hi.g | (hi.p & lo_g);
endmodule

// File: rtl/ppa_pipe_stage.sv
// Register slice with a valid bit, a global enable and synchronous clear.
module ppa_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          valid_d,
  input  logic [DW-1:0] data_d,
  output logic          valid_q,
  output logic [DW-1:0] data_q
);
  // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
  // NOTE: payload is cleared as well so the output slice reads zero while idle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/ppa_sub_pipe.sv
// Pipelined Brent-Kung subtractor: diff = a - b - bin, computed as a + ~b + ~bin,
// one register per prefix level behind a globally stalled valid/ready stream.
module ppa_sub_pipe
  import ppa_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LOG2W = 2
) (
  input logic          clk,
  input logic          rst,
  ppa_sub_pipe_if.slave bus
);
  localparam int NL      = bk_levels(WIDTH);
  localparam int LATENCY = 2 * LOG2W + 1;

  if (WIDTH < 2 || !is_pow2(WIDTH) || LOG2W != $clog2(WIDTH) || LATENCY != NL + 2) begin : g_bad_param
    $error("ppa_sub_pipe: WIDTH must be a power of two >= 2 and LOG2W must equal clog2(WIDTH)");
  end

  typedef struct packed {
    pg_t [WIDTH-1:0] pg;
    logic [WIDTH-1:0] p0;
    logic             cin;
    logic             a_msb;
    logic             b_msb;
  } beat_t;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;
  } res_t;

  logic             stall;
  logic             out_v_q;
  beat_t            pre;
  beat_t            st_q [0:NL];
  logic             st_v [0:NL];
  logic [WIDTH-1:0] carry;
  res_t             res_d;
  res_t             res_q;

  assign stall        = out_v_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pre = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pre.pg[i] = '{p: bus.a[i] ^ ~bus.b[i], g: bus.a[i] & ~bus.b[i]};
    end
    pre.p0    = bus.a ^ ~bus.b;
    pre.cin   = ~bus.bin;
    pre.a_msb = bus.a[WIDTH-1];
    pre.b_msb = bus.b[WIDTH-1];
  end

  ppa_pipe_stage #(.DW($bits(beat_t))) u_pre (
    .clk     (clk),
    .rst     (rst),
    .en      (~stall),
    .valid_d (bus.in_valid),
    .data_d  (pre),
    .valid_q (st_v[0]),
    .data_q  (st_q[0])
  );

  // Levels 1..LOG2W are the up-sweep (span doubling), the rest the down-sweep (span halving).
  for (genvar k = 1; k <= NL; k++) begin : g_lvl
    localparam bit UP   = (k <= LOG2W);
    localparam int SPAN = UP ? (1 << (k - 1)) : (1 << (2 * LOG2W - 1 - k));

    pg_t   nxt [WIDTH];
    beat_t lvl_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (UP ? ((i + 1) % (2 * SPAN) == 0)
             : (((i + 1) % (2 * SPAN) == SPAN) && (i >= 2 * SPAN))) begin : g_cell
        ppa_black u_cell (
          .hi (st_q[k-1].pg[i]),
          .lo (st_q[k-1].pg[i-SPAN]),
          .o  (nxt[i])
        );
      end else begin : g_pass
        assign nxt[i] = st_q[k-1].pg[i];
      end
    end

    always_comb begin
      lvl_d = st_q[k-1];
      for (int i = 0; i < WIDTH; i++) lvl_d.pg[i] = nxt[i];
    end

    ppa_pipe_stage #(.DW($bits(beat_t))) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (~stall),
      .valid_d (st_v[k-1]),
      .data_d  (lvl_d),
      .valid_q (st_v[k]),
      .data_q  (st_q[k])
    );
  end

  // The carry-in is the p=0 entry below bit 0; folding it here turns G[i:0] into G[i:-1].
  for (genvar i = 0; i < WIDTH; i++) begin : g_post
    ppa_grey u_cin (
      .hi   (st_q[NL].pg[i]),
      .lo_g (st_q[NL].cin),
      .g    (carry[i])
    );
  end

  always_comb begin
    res_d = '0;
    if (st_v[NL]) begin
      res_d.diff = st_q[NL].p0 ^ {carry[WIDTH-2:0], st_q[NL].cin};
      res_d.bout = ~carry[WIDTH-1];
      res_d.zero = ~|res_d.diff;
      res_d.ovf  = (st_q[NL].a_msb ^ st_q[NL].b_msb) & (st_q[NL].a_msb ^ res_d.diff[WIDTH-1]);
    end
  end

  ppa_pipe_stage #(.DW($bits(res_t))) u_out (
    .clk     (clk),
    .rst     (rst),
    .en      (~stall),
    .valid_d (st_v[NL]),
    .data_d  (res_d),
    .valid_q (out_v_q),
    .data_q  (res_q)
  );

  assign bus.out_valid = out_v_q;
  assign bus.diff      = res_q.diff;
  assign bus.bout      = res_q.bout;
  assign bus.zero      = res_q.zero;
  assign bus.ovf       = res_q.ovf;

endmodule

// File: tb/tb_ppa_sub_pipe.sv
// Self-checking bench for ppa_sub_pipe: directed vector table, streaming, stall,
// reset-flush and an exhaustive sweep against an arithmetic reference model.
module tb_ppa_sub_pipe;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    res_t         want;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ppa_sub_pipe_if #(.WIDTH(W)) bus ();

  ppa_sub_pipe #(.WIDTH(W), .LOG2W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t sb[$];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for borrow and signed range for overflow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    res_t r;
    int   u, s, sa, sb_v;
    u    = int'(a) - int'(b) - int'(bin);
    sa   = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb_v = b[W-1] ? int'(b) - (1 << W) : int'(b);
    s    = sa - sb_v - int'(bin);
    r.diff = u[W-1:0];
    r.bout = (u < 0);
    r.zero = (r.diff == '0);
    r.ovf  = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
    return r;
  endfunction

  function automatic res_t dut_out();
    return res_t'({bus.diff, bus.bout, bus.zero, bus.ovf});
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input logic v);
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = v;
  endtask

  // One clock: evaluate both handshakes mid-cycle, score them, return just after the next edge.
  task automatic tick(input bit expect_stall, output bit acc, output bit take);
    res_t want;
    @(negedge clk);
    acc  = bus.in_valid && bus.in_ready && !rst;
    take = bus.out_valid && bus.out_ready;
    if (expect_stall) begin
      check("stall_in_ready", int'(bus.in_ready), 0);
      check("stall_out_valid", int'(bus.out_valid), 1);
      if (sb.size() > 0) check("stall_payload", int'(dut_out()), int'(sb[0]));
    end
    if (take) begin
      if (sb.size() == 0) check("unexpected_beat", int'(bus.out_valid), 0);
      else begin
        want = sb.pop_front();
        check("result", int'(dut_out()), int'(want));
      end
    end
    if (acc) sb.push_back(model(bus.a, bus.b, bus.bin));
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    drive(v.a, v.b, v.bin, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("vec_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
    check("vec_latency", lat, 5);
    check("vec_diff", int'(bus.diff), int'(v.want.diff));
    check("vec_bout", int'(bus.bout), int'(v.want.bout));
    check("vec_zero", int'(bus.zero), int'(v.want.zero));
    check("vec_ovf", int'(bus.ovf), int'(v.want.ovf));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    bit   acc, take;
    int   first, got, issued, ir_low, stray, tries;

    vecs[0] = '{a: 4'h9, b: 4'h3, bin: 1'b0, want: '{diff: 4'h6, bout: 1'b0, zero: 1'b0, ovf: 1'b1}};
    vecs[1] = '{a: 4'h3, b: 4'h9, bin: 1'b1, want: '{diff: 4'h9, bout: 1'b1, zero: 1'b0, ovf: 1'b1}};
    vecs[2] = '{a: 4'h8, b: 4'h1, bin: 1'b0, want: '{diff: 4'h7, bout: 1'b0, zero: 1'b0, ovf: 1'b1}};
    vecs[3] = '{a: 4'h5, b: 4'h5, bin: 1'b0, want: '{diff: 4'h0, bout: 1'b0, zero: 1'b1, ovf: 1'b0}};
    vecs[4] = '{a: 4'h0, b: 4'h0, bin: 1'b1, want: '{diff: 4'hF, bout: 1'b1, zero: 1'b0, ovf: 1'b0}};
    vecs[5] = '{a: 4'h7, b: 4'hF, bin: 1'b0, want: '{diff: 4'h8, bout: 1'b1, zero: 1'b0, ovf: 1'b1}};
    vecs[6] = '{a: 4'h0, b: 4'h0, bin: 1'b0, want: '{diff: 4'h0, bout: 1'b0, zero: 1'b1, ovf: 1'b0}};
    vecs[7] = '{a: 4'hF, b: 4'h0, bin: 1'b1, want: '{diff: 4'hE, bout: 1'b0, zero: 1'b0, ovf: 1'b0}};

    // Reset state
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_payload", int'(dut_out()), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Directed vectors with latency
    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back stream of 16 beats
    bus.out_ready = 1'b1;
    first = -1; got = 0; issued = 0; ir_low = 0;
    for (int cyc = 0; cyc < 60 && (issued < 16 || sb.size() > 0); cyc++) begin
      if (issued < 16) drive(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
      else bus.in_valid = 1'b0;
      tick(1'b0, acc, take);
      if (issued < 16 && !acc) ir_low++;
      if (acc) issued++;
      if (take) begin
        got++;
        if (first < 0) first = cyc;
      end
    end
    check("stream_first_cycle", first, 5);
    check("stream_results", got, 16);
    check("stream_in_ready_low", ir_low, 0);

    // Stall with a full pipeline, then release
    issued = 0; got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
      bus.out_ready = !(cyc >= 8 && cyc < 14);
      tick(cyc >= 8 && cyc < 14, acc, take);
      if (acc) issued++;
      if (take) got++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 30 && sb.size() > 0; n++) begin
      tick(1'b0, acc, take);
      if (take) got++;
    end
    check("stall_count", got, issued);
    check("stall_drained", sb.size(), 0);

    // Reset with three beats in flight; a beat offered during reset must be dropped
    for (int n = 0; n < 3; n++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
      tick(1'b0, acc, take);
    end
    drive(4'hA, 4'h3, 1'b0, 1'b1);
    rst = 1'b1;
    tick(1'b0, acc, take);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", int'(bus.out_valid), 0);
    check("flush_in_ready", int'(bus.in_ready), 1);
    stray = 0;
    for (int n = 0; n < 10; n++) begin
      tick(1'b0, acc, take);
      if (take) stray++;
    end
    check("flush_stray", stray, 0);

    // Exhaustive sweep under random back-pressure
    got = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          drive(4'(a), 4'(b), 1'(c), 1'b1);
          tries = 0;
          do begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick(1'b0, acc, take);
            if (take) got++;
            tries++;
          end while (!acc && tries < 50);
          if (!acc) check("sweep_accept", int'(acc), 1);
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 40 && sb.size() > 0; n++) begin
      tick(1'b0, acc, take);
      if (take) got++;
    end
    check("sweep_results", got, 512);
    check("sweep_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
